// File: rtl/if_id_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the instruction-fetch stage and IF/ID register:
//   fetch_state_t     - fetch FSM states (REQ, WAIT, DROP)
//   NOP_INSTR         - instruction value of an IF/ID bubble
//   RS_*/RT_*         - register-specifier field positions in an instruction
//   RESET_PC_DEFAULT  - default PC loaded on reset
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int unsigned RS_MSB           = 25;
    localparam int unsigned RS_LSB           = 21;
    localparam int unsigned RT_MSB           = 20;
    localparam int unsigned RT_LSB           = 16;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_fetch_stage_if
// Instruction-memory request/response bus.
//   IMem_Req   - request valid (fetch stage -> memory)
//   IMem_Addr  - request byte address (fetch stage -> memory)
//   IMem_Ready - memory accepts the request this cycle
//   IMem_Valid - one-cycle response pulse, in order
//   IMem_Data  - response instruction
// Modports: master (fetch stage), slave (instruction memory).
// -----------------------------------------------------------------------------
interface if_id_fetch_stage_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) ();

    logic               IMem_Req;
    logic [PC_W-1:0]    IMem_Addr;
    logic               IMem_Ready;
    logic               IMem_Valid;
    logic [INSTR_W-1:0] IMem_Data;

    modport master (
        output IMem_Req,
        output IMem_Addr,
        input  IMem_Ready,
        input  IMem_Valid,
        input  IMem_Data
    );

    modport slave (
        input  IMem_Req,
        input  IMem_Addr,
        output IMem_Ready,
        output IMem_Valid,
        output IMem_Data
    );

endinterface

// File: rtl/if_id_fetch_stage_skid.sv
// -----------------------------------------------------------------------------
// if_skid_buffer
// One-entry holding register for an instruction (and its PC+4) that returned
// from memory while the IF/ID register was stalled.
//   Clk, Reset_n       - clock, asynchronous active-low reset
//   clear              - discard the held entry (flush), highest priority
//   unload             - entry consumed by IF/ID this cycle
//   load               - capture load_instr/load_pc4
//   full               - entry held
//   instr, pc4         - held instruction and its PC+4
// -----------------------------------------------------------------------------
module if_skid_buffer #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               clear,
    input  logic               unload,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc4,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc4
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            full  <= 1'b0;
            instr <= '0;
            pc4   <= '0;
        end else if (clear || unload) begin
            full  <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc4   <= load_pc4;
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_id_fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, issues
// single-outstanding requests to instruction memory, parks returned
// instructions in a skid entry while stalled and squashes on EX redirects.
//   Clk, Reset_n        - clock, asynchronous active-low reset
//   Stall               - hazard stall: freeze PC and IF/ID
//   Branch_Taken_EX     - taken branch/jump resolved in EX (flush + redirect)
//   Branch_Target_EX    - redirect target (bits [1:0] ignored)
//   imem                - instruction-memory bus (master side)
//   Valid_ID, Instr_ID  - IF/ID contents (Instr_ID = 0 on a bubble)
//   PC_Plus4_ID         - PC+4 of the instruction in ID
//   Rs_ID, Rt_ID        - register fields of Instr_ID, for the hazard detector
// Optional build macro IF_ID_PERF_CNT_EN adds Fetch_Cnt, Stall_Cnt, Flush_Cnt.
// -----------------------------------------------------------------------------
module if_id_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Stall,
    input  logic                Branch_Taken_EX,
    input  logic [PC_W-1:0]     Branch_Target_EX,
    if_id_fetch_stage_if.master imem,
    output logic                Valid_ID,
    output logic [INSTR_W-1:0]  Instr_ID,
    output logic [PC_W-1:0]     PC_Plus4_ID,
    output logic [4:0]          Rs_ID,
    output logic [4:0]          Rt_ID
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]         Fetch_Cnt,
    output logic [31:0]         Stall_Cnt,
    output logic [15:0]         Flush_Cnt
`endif
);

    fetch_state_t       state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    req_pc;
    logic               req_q;

    logic               flush;
    logic               accept;
    logic               deliver;
    logic               next_in_req;
    logic               skid_full;
    logic               skid_load;
    logic               skid_unload;
    logic               skid_full_next;
    logic               id_load;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc4;
    logic [PC_W-1:0]    target_aligned;
    logic [PC_W-1:0]    req_pc_plus4;

    assign flush          = Branch_Taken_EX;
    assign target_aligned = {Branch_Target_EX[PC_W-1:2], 2'b00};
    assign req_pc_plus4   = req_pc + PC_W'(4);

    // req_q is only ever set while in REQ, so it doubles as the state qualifier.
    assign accept  = req_q && imem.IMem_Ready && !flush;
    assign deliver = (state == WAIT) && imem.IMem_Valid && !flush;

    assign skid_unload    = skid_full && !Stall && !flush;
    assign skid_load      = deliver && Stall;
    assign skid_full_next = !flush && Stall && (skid_full || deliver);
    assign id_load        = !flush && !Stall && (skid_full || deliver);

    // REQ is left only on acceptance; WAIT and DROP both return on a response.
    assign next_in_req = (state == REQ) ? !accept : imem.IMem_Valid;

    assign imem.IMem_Req  = req_q;
    assign imem.IMem_Addr = pc;

    // Fetch FSM. The PC advances on every delivered response, stalled or not,
    // because a stalled response lands in the skid entry and must not be
    // refetched; a full skid withholds further requests (hold inside REQ).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            req_q  <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (flush) begin
                        pc <= target_aligned;
                    end else if (accept) begin
                        state  <= WAIT;
                        req_pc <= pc;
                    end
                end
                WAIT: begin
                    if (imem.IMem_Valid) begin
                        state <= REQ;
                        pc    <= flush ? target_aligned : req_pc_plus4;
                    end else if (flush) begin
                        state <= DROP;
                        pc    <= target_aligned;
                    end
                end
                DROP: begin
                    if (flush) begin
                        pc <= target_aligned;
                    end
                    if (imem.IMem_Valid) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
            req_q <= next_in_req && !skid_full_next;
        end
    end

    if_skid_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .clear      (flush),
        .unload     (skid_unload),
        .load       (skid_load),
        .load_instr (imem.IMem_Data),
        .load_pc4   (req_pc_plus4),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc4        (skid_pc4)
    );

    // IF/ID register. Flush beats Stall; a bubble keeps the old PC+4.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Valid_ID    <= 1'b0;
            Instr_ID    <= INSTR_W'(NOP_INSTR);
            PC_Plus4_ID <= '0;
        end else if (flush) begin
            Valid_ID    <= 1'b0;
            Instr_ID    <= INSTR_W'(NOP_INSTR);
        end else if (!Stall) begin
            if (skid_full) begin
                Valid_ID    <= 1'b1;
                Instr_ID    <= skid_instr;
                PC_Plus4_ID <= skid_pc4;
            end else if (deliver) begin
                Valid_ID    <= 1'b1;
                Instr_ID    <= imem.IMem_Data;
                PC_Plus4_ID <= req_pc_plus4;
            end else begin
                Valid_ID    <= 1'b0;
                Instr_ID    <= INSTR_W'(NOP_INSTR);
            end
        end
    end

    assign Rs_ID = Instr_ID[RS_MSB:RS_LSB];
    assign Rt_ID = Instr_ID[RT_MSB:RT_LSB];

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Fetch_Cnt <= '0;
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
        end else begin
            if (id_load) begin
                Fetch_Cnt <= Fetch_Cnt + 32'd1;
            end
            if (Stall && Valid_ID) begin
                Stall_Cnt <= Stall_Cnt + 32'd1;
            end
            if (flush) begin
                Flush_Cnt <= Flush_Cnt + 16'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = id_load ^ skid_unload;
`endif

endmodule
